// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared states, frame constants and parity helper for the SIPO receiver
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Even parity over up to 16 data bits; callers zero-extend narrower words
  function automatic logic even_parity(input logic [15:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// rtl/sipo_out_buffer.sv - one-entry valid/ready holding register with overrun detection
module sipo_out_buffer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             parity_err,
  output logic             overrun
);

  logic accept;
  logic drop;

  // A new word fits when the slot is empty or is being consumed on this edge
  assign accept = load && (!out_valid || out_ready);
  assign drop   = load && out_valid && !out_ready;

  // Holding register: load wins over a plain handshake clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parallel_out <= '0;
      parity_err   <= 1'b0;
      out_valid    <= 1'b0;
    end else if (accept) begin
      parallel_out <= load_data;
      parity_err   <= load_perr;
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop beats a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_err) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_frame_receiver.sv
// rtl/sipo_frame_receiver.sv - serial frame receiver: start, data, optional parity, stop
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             shift,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clear_err
);

  localparam int CNT_W = $clog2(WIDTH);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             par_q, par_d;
  logic             word_done;
  logic             frame_set;
  logic             perr_calc;

  // Parity mismatch of the assembled word against the received parity bit
  assign perr_calc = (PARITY_EN != 0) && (even_parity(16'(acc_q)) != par_q);

  // FSM, bit counter, accumulator and captured parity registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic; nothing moves on edges without a shift strobe
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    par_d     = par_q;
    word_done = 1'b0;
    frame_set = 1'b0;
    if (shift) begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_d = DATA;
            count_d = '0;
          end
        end
        DATA: begin
          if (MSB_FIRST != 0) acc_d = {acc_q[WIDTH-2:0], serial_in};
          else                acc_d = {serial_in, acc_q[WIDTH-1:1]};
          if (count_q == CNT_W'(WIDTH - 1)) begin
            count_d = '0;
            state_d = (PARITY_EN != 0) ? PAR : STOP;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        PAR: begin
          par_d   = serial_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in == STOP_BIT) word_done = 1'b1;
          else                       frame_set = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky framing error; a new bad stop bit beats a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else if (frame_set) begin
      frame_err <= 1'b1;
    end else if (clear_err) begin
      frame_err <= 1'b0;
    end
  end

  sipo_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (word_done),
    .load_data    (acc_q),
    .load_perr    (perr_calc),
    .out_ready    (out_ready),
    .clear_err    (clear_err),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .parity_err   (parity_err),
    .overrun      (overrun)
  );

endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
Serial-to-parallel receiver that consumes the single-bit stream produced by the team's PISO shift stage. The stream is sampled on clock edges where shift=1. The block detects a start bit, assembles WIDTH data bits MSB-first, and checks an optional even-parity bit and a stop bit. Each recovered word is presented downstream through a one-entry valid/ready output register.

Parameters:
WIDTH, 4, data bits per frame (legal range 2..16)
PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit
MSB_FIRST, 1, 1 = first data bit received goes to parallel_out[WIDTH-1]; 0 = first bit goes to parallel_out[0]

Ports:
clock  input  1  single system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
serial_in  input  1  serial data bit, sampled only when shift=1
shift  input  1  bit strobe; one frame bit is consumed per clock edge with shift=1
parallel_out  output  WIDTH  recovered data word, stable while out_valid=1
out_valid  output  1  parallel_out holds an unconsumed word
out_ready  input  1  downstream accepts the word on a clock edge where out_valid&&out_ready
parity_err  output  1  per-word flag, qualified by out_valid; 1 = parity mismatch on this word
frame_err  output  1  sticky; set on a bad stop bit, cleared by clear_err or reset
overrun  output  1  sticky; set when a completed word is dropped, cleared by clear_err or reset
clear_err  input  1  synchronous clear of frame_err and overrun

Behaviour:
- Reset: the asynchronous assertion of reset_n forces the following, with no clock required:
  - state=IDLE, bit counter=0, shift accumulator=0;
  - parallel_out=0, out_valid=0, parity_err=0, frame_err=0, overrun=0.
  - A reset mid-frame discards the partial frame.
- Bits are sampled only on edges with shift=1. Edges with shift=0 hold all FSM state, count and accumulator.
- Frame format: start (1), WIDTH data bits, parity bit (only if PARITY_EN), stop (0).
- FSM states:
  - IDLE: on shift && serial_in==1, go to DATA with count=0. A 0 sampled in IDLE is ignored (line idle).
  - DATA: shift the sampled bit into the accumulator and increment count. After the WIDTH-th bit, go to PAR if PARITY_EN, else STOP.
  - PAR: capture the received parity bit, then go to STOP.
  - STOP: on the sampled bit, always return to IDLE.
    - If the bit is 0: the word completes (see output register rules).
    - If the bit is 1: set frame_err and discard the word.
- Parity: even parity, computed as the XOR of the data bits. parity_err=1 when that XOR != the received parity bit. The word is still delivered; parity_err is loaded together with parallel_out. With PARITY_EN=0, parity_err is always 0.
- Output register (one entry):
  - A word completes on the STOP sample edge; out_valid=1 and parallel_out are visible from the next cycle.
  - Latency is 1 cycle after the stop-bit edge.
  - While out_valid=1 and out_ready=0, parallel_out and parity_err hold.
  - A handshake (out_valid && out_ready) clears out_valid on that edge, unless a new word loads in the same edge.
- Simultaneous completion and handshake on the same edge: the old word is consumed, the new word loads, out_valid stays 1, and overrun is not set.
- Completion while out_valid=1 and out_ready=0: the new word is dropped, the held word is kept, and overrun is set.
- clear_err and a new error on the same edge: the set wins.
- The counter wraps only via the FSM; a count beyond WIDTH-1 is unreachable.

Decomposition:
- Package sipo_pkg holds:
  - typedef enum logic [1:0] rx_state_t {IDLE, DATA, PAR, STOP};
  - localparams START_BIT=1'b1 and STOP_BIT=1'b0;
  - a function even_parity(data).
- One sub-module, sipo_out_buffer: the one-entry valid/ready holding register with overrun detection, parameterised by WIDTH.
- The FSM, counter and accumulator stay in the top-level module.

Test Plan:
1. WIDTH=4, PARITY_EN=1, shift held 1: serial_in sequence 1,1,0,1,1,1,0 (start, data 1011, parity 1, stop) with out_ready=1 -> one cycle after the stop edge: out_valid=1, parallel_out=4'hB, parity_err=0.
2. Same frame with the parity bit changed to 0 -> parallel_out=4'hB, parity_err=1; frame_err and overrun stay 0.
3. Frame 1,0,1,1,0,0,1 (stop bit=1) -> out_valid stays 0, frame_err=1 until a clear_err pulse, then frame_err=0.
4. Two back-to-back frames 4'hB then 4'h6 with out_ready=0 throughout -> parallel_out stays 4'hB and overrun=1. Raising out_ready for one cycle then drops out_valid.
5. shift toggled 1,0,0,1,... mid-frame (gaps between bits) for data 0110 -> parallel_out=4'h6, same result as continuous shift.
6. reset_n pulsed low after the start bit and 2 data bits -> all outputs are 0 immediately. A following full frame 4'hB then decodes correctly.
